lcp_dma_engine: RTL

Tile-local DMA engine that consumes 128-bit DMA commands dispatched by the local command processor (LCP) over its `dma_cmd` valid/ready channel. It moves 2-D blocks of words between external memory and the tile's local SRAM. It reports completion on a single-cycle `done` pulse, which feeds the LCP's `dma_done` input and drives `SYNC DMA` waits. It handles one command at a time and keeps at most one memory beat in flight.

---
 rtl/lcp_dma_engine.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/lcp_dma_engine.sv
// Tile-local 2-D DMA engine: moves rows x cols words between external memory and
// local SRAM, one command and at most one memory beat in flight at a time.
module lcp_dma_engine #(
    parameter int DATA_W = 256,
    parameter int EXT_AW = 40,
    parameter int LOC_AW = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [127:0]      cmd,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic              done,
    output logic              error,
    output logic              busy,
    output logic [EXT_AW-1:0] ext_addr_o,
    output logic              ext_re,
    output logic              ext_we,
    output logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_ready,
    input  logic              ext_rvalid,
    input  logic [DATA_W-1:0] ext_rdata,
    output logic [LOC_AW-1:0] sram_addr,
    output logic              sram_we,
    output logic              sram_re,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    localparam logic [EXT_AW-1:0] BYTES = EXT_AW'(DATA_W / 8);

    typedef enum logic [3:0] {
        IDLE, DECODE, L_REQ, L_WAIT, L_WR, S_RD, S_CAP, S_REQ, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         op_q, op_d, sub_q, sub_d;
    logic [11:0]        rows_q, rows_d, cols_q, cols_d, row_q, row_d, col_q, col_d;
    logic [19:0]        stride_q, stride_d;
    logic [EXT_AW-1:0]  ea_q, ea_d, base_q, base_d;
    logic [LOC_AW-1:0]  la_q, la_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               err_q, err_d;
    logic               advance;
    logic               unused_rsvd;

    assign unused_rsvd = ^cmd[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sub_q    <= '0;
            rows_q   <= '0;
            cols_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            stride_q <= '0;
            ea_q     <= '0;
            base_q   <= '0;
            la_q     <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sub_q    <= sub_d;
            rows_q   <= rows_d;
            cols_q   <= cols_d;
            row_q    <= row_d;
            col_q    <= col_d;
            stride_q <= stride_d;
            ea_q     <= ea_d;
            base_q   <= base_d;
            la_q     <= la_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sub_d      = sub_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        row_d      = row_q;
        col_d      = col_q;
        stride_d   = stride_q;
        ea_d       = ea_q;
        base_d     = base_q;
        la_d       = la_q;
        data_d     = data_q;
        err_d      = err_q;
        advance    = 1'b0;
        cmd_ready  = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        ext_addr_o = '0;
        ext_re     = 1'b0;
        ext_we     = 1'b0;
        ext_wdata  = '0;
        sram_addr  = '0;
        sram_we    = 1'b0;
        sram_re    = 1'b0;
        sram_wdata = '0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d     = cmd[127:120];
                    sub_d    = cmd[119:112];
                    ea_d     = EXT_AW'(cmd[111:72]);
                    base_d   = EXT_AW'(cmd[111:72]);
                    la_d     = LOC_AW'(cmd[71:52]);
                    rows_d   = cmd[51:40];
                    cols_d   = cmd[39:28];
                    stride_d = cmd[27:8];
                    row_d    = '0;
                    col_d    = '0;
                    err_d    = 1'b0;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                if (op_q != 8'h03 || (sub_q != 8'h01 && sub_q != 8'h02)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (rows_q == '0 || cols_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = (sub_q == 8'h01) ? L_REQ : S_RD;
                end
            end
            L_REQ: begin
                ext_re     = 1'b1;
                ext_addr_o = ea_q;
                if (ext_ready) state_d = L_WAIT;
            end
            L_WAIT: begin
                if (ext_rvalid) begin
                    data_d  = ext_rdata;
                    state_d = L_WR;
                end
            end
            L_WR: begin
                sram_we    = 1'b1;
                sram_addr  = la_q;
                sram_wdata = data_q;
                advance    = 1'b1;
            end
            S_RD: begin
                sram_re   = 1'b1;
                sram_addr = la_q;
                state_d   = S_CAP;
            end
            S_CAP: begin
                // SRAM read data is valid in the cycle after sram_re
                data_d  = sram_rdata;
                state_d = S_REQ;
            end
            S_REQ: begin
                ext_we     = 1'b1;
                ext_addr_o = ea_q;
                ext_wdata  = data_q;
                advance    = ext_ready;
            end
            DONE: begin
                done    = 1'b1;
                error   = err_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            la_d = la_q + 1'b1;
            if (col_q == cols_q - 12'd1) begin
                col_d  = '0;
                row_d  = row_q + 12'd1;
                ea_d   = base_q + EXT_AW'(stride_q);
                base_d = base_q + EXT_AW'(stride_q);
            end else begin
                col_d = col_q + 12'd1;
                ea_d  = ea_q + BYTES;
            end
            if (col_q == cols_q - 12'd1 && row_q == rows_q - 12'd1)
                state_d = DONE;
            else
                state_d = (sub_q == 8'h01) ? L_REQ : S_RD;
        end
    end

    assign busy = (state_q != IDLE);

endmodule
